// File: rtl/mult_seq_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mult_seq_pkg;

  localparam int unsigned MUL_WIDTH   = 32;
  localparam int unsigned MUL_CNT_W   = 6;
  // Start edge to result edge; the control unit stalls on the same count.
  localparam int unsigned MUL_LATENCY = MUL_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_if.sv
// Start/busy/done handshake and operand/result bus between control unit and multiplier.
interface mult_seq_if
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_seq_twos_abs.sv
// Conditional two's-complement negate: yields the magnitude when en is set.
module twos_abs
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic [WIDTH-1:0] mag
);

  always_comb begin
    mag = en ? (~value + WIDTH'(1)) : value;
  end

endmodule

// File: rtl/mult_seq.sv
// Sequential WIDTHxWIDTH shift-add multiplier, signed via magnitudes, fixed latency.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned CNT_W = MUL_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_seq_if.slave   bus
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] abs_a, abs_b;

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value (bus.multiplicand),
    .en    (bus.is_signed & bus.multiplicand[WIDTH-1]),
    .mag   (abs_a)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value (bus.multiplier),
    .en    (bus.is_signed & bus.multiplier[WIDTH-1]),
    .mag   (abs_b)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mag_a_d = {{WIDTH{1'b0}}, abs_a};
          mag_b_d = abs_b;
          neg_d   = bus.is_signed & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mag_b_q[0]) acc_d = acc_q + mag_a_q;
        mag_a_d = mag_a_q << 1;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q - CNT_W'(1);
        // Always runs the full count, even once mag_b is exhausted.
        if (cnt_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        {hi_d, lo_d} = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: driver queues reference products, monitor checks on done.
module tb_mult_seq;

  localparam int unsigned W = 32;
  // Driver raises start just before edge E0; done is sampled after E33.
  localparam int unsigned DONE_LAG = 34;

  typedef struct {
    logic [63:0] prod;
    int unsigned k;
  } exp_t;

  logic clk;
  logic rst_n;
  int unsigned cyc;

  exp_t        sb_q[$];
  int unsigned n_vec;
  int unsigned n_fail;
  logic [63:0] exp_res;
  logic        prev_done;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops on done, otherwise checks the result registers are held.
  initial begin
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        chk("done_width", 64'(prev_done), 64'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("hi", 64'(bus.hi), 64'(e.prod[63:32]));
          chk("lo", 64'(bus.lo), 64'(e.prod[31:0]));
          chk("latency", 64'(cyc - e.k), 64'(DONE_LAG));
          exp_res = e.prod;
        end
      end else begin
        chk("hold", {bus.hi, bus.lo}, exp_res);
      end
      prev_done = bus.done;
    end
  end

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    wait_idle();
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.is_signed    = s;
    bus.start        = 1'b1;
    e.prod = ref_mul(a, b, s);
    e.k    = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    // Operand changes while busy must not disturb the running product.
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    bus.is_signed    = 1'($urandom);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_vec     = 0;
    n_fail    = 0;
    exp_res   = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.is_signed    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    // Reset holds everything at zero even with start pulsed.
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 32'd5;
    bus.multiplier   = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi",   64'(bus.hi),   64'd0);
    chk("rst_lo",   64'(bus.lo),   64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 64'(bus.busy), 64'd0);

    // Directed corners, issued back-to-back.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(32'hFFFF_FFF9, 32'h0000_0003, 1'b1);
    issue(32'hFFFF_FFF9, 32'h0000_0003, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(32'h0000_0000, 32'hFFFF_FFFB, 1'b1);

    // Start during RUN must be ignored, not queued.
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 32'h0000_0002;
    bus.multiplier   = 32'h0000_0003;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-RUN discards the operation.
    issue(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(bus.busy), 64'd0);
    chk("async_done", 64'(bus.done), 64'd0);
    chk("async_hilo", {bus.hi, bus.lo}, 64'd0);
    sb_q.delete();
    exp_res = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", 64'(bus.busy), 64'd0);

    issue(32'h0000_0011, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 40; i++) issue(pick(), pick(), 1'($urandom));

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
